// File: rtl/pong_frame_renderer_pkg.sv
// Shared types, VGA timing constants, control-word layout and geometry helpers
// for the Pong frame renderer.
package pong_pkg;

   typedef logic [11:0] rgb444_t;
   typedef logic [9:0]  coord_t;

   localparam int H_ACTIVE     = 32'd640;
   localparam int H_FP         = 32'd16;
   localparam int H_SYNC       = 32'd96;
   localparam int H_BP         = 32'd48;
   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

   localparam int V_ACTIVE     = 32'd480;
   localparam int V_FP         = 32'd10;
   localparam int V_SYNC       = 32'd2;
   localparam int V_BP         = 32'd33;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int PADDLE_W     = 32'd8;
   localparam int PADDLE_H     = 32'd64;
   localparam int PADDLE_L_X   = 32'd16;
   localparam int PADDLE_R_X   = 32'd616;
   localparam int BALL_SIZE    = 32'd8;

   localparam int CTRL_EN_BIT  = 32'd0;
   localparam int CTRL_FG_LSB  = 32'd4;
   localparam int CTRL_BG_LSB  = 32'd16;

   // Bounds are widened to 11 bits so lo+len never wraps past 1023.
   function automatic logic in_span(coord_t pos, coord_t lo, logic [10:0] len);
      logic [10:0] pos_w;
      logic [10:0] lo_w;
      pos_w = {1'b0, pos};
      lo_w  = {1'b0, lo};
      return (pos_w >= lo_w) && (pos_w < (lo_w + len));
   endfunction

   function automatic coord_t clamp_paddle(coord_t y, coord_t limit);
      return (y > limit) ? limit : y;
   endfunction

endpackage

// File: rtl/pong_frame_renderer_if.sv
// Register inputs from the AXI-Lite slave and the VGA/frame outputs of the renderer.
interface pong_frame_renderer_if;
   import pong_pkg::*;

   logic        pix_ce;
   coord_t      reg_paddle_l;
   coord_t      reg_paddle_r;
   coord_t      reg_ball_x;
   coord_t      reg_ball_y;
   logic [31:0] reg_ctrl;
   logic        vga_hs;
   logic        vga_vs;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        frame_start;
   logic [15:0] frame_cnt;

   modport master (
      output pix_ce, reg_paddle_l, reg_paddle_r, reg_ball_x, reg_ball_y, reg_ctrl,
      input  vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start, frame_cnt
   );

   modport slave (
      input  pix_ce, reg_paddle_l, reg_paddle_r, reg_ball_x, reg_ball_y, reg_ctrl,
      output vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start, frame_cnt
   );

endinterface

// File: rtl/pong_frame_renderer_vga_timing_gen.sv
// Pixel/line counters with raw sync, active-area and end-of-active-frame strobe.
module vga_timing_gen
   import pong_pkg::*;
#(
   parameter int H_VIS    = H_ACTIVE,
   parameter int H_FPORCH = H_FP,
   parameter int H_SYNCW  = H_SYNC,
   parameter int H_BPORCH = H_BP,
   parameter int V_VIS    = V_ACTIVE,
   parameter int V_FPORCH = V_FP,
   parameter int V_SYNCW  = V_SYNC,
   parameter int V_BPORCH = V_BP
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   pix_ce,
   output coord_t h_cnt,
   output coord_t v_cnt,
   output logic   hs_raw,
   output logic   vs_raw,
   output logic   active,
   output logic   frame_end
);

   localparam int H_TOT    = H_VIS + H_FPORCH + H_SYNCW + H_BPORCH;
   localparam int V_TOT    = V_VIS + V_FPORCH + V_SYNCW + V_BPORCH;
   localparam int HS_START = H_VIS + H_FPORCH;
   localparam int HS_END   = HS_START + H_SYNCW;
   localparam int VS_START = V_VIS + V_FPORCH;
   localparam int VS_END   = VS_START + V_SYNCW;

   coord_t h_cnt_r;
   coord_t v_cnt_r;
   logic   h_last_s;
   logic   v_last_s;

   assign h_last_s = (h_cnt_r == coord_t'(H_TOT - 1));
   assign v_last_s = (v_cnt_r == coord_t'(V_TOT - 1));

   // Raster position advances one pixel per pix_ce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_r <= 10'd0;
         v_cnt_r <= 10'd0;
      end else if (pix_ce) begin
         if (h_last_s) begin
            h_cnt_r <= 10'd0;
            v_cnt_r <= v_last_s ? 10'd0 : (v_cnt_r + 10'd1);
         end else begin
            h_cnt_r <= h_cnt_r + 10'd1;
         end
      end
   end

   assign h_cnt     = h_cnt_r;
   assign v_cnt     = v_cnt_r;
   assign hs_raw    = !((h_cnt_r >= coord_t'(HS_START)) && (h_cnt_r < coord_t'(HS_END)));
   assign vs_raw    = !((v_cnt_r >= coord_t'(VS_START)) && (v_cnt_r < coord_t'(VS_END)));
   assign active    = (h_cnt_r < coord_t'(H_VIS)) && (v_cnt_r < coord_t'(V_VIS));
   assign frame_end = pix_ce && h_last_s && (v_cnt_r == coord_t'(V_VIS - 1));

endmodule

// File: rtl/pong_frame_renderer.sv
// Pong renderer: per-frame register shadowing, paddle/ball hit tests and a
// two-stage pix_ce pipeline producing VGA sync and RGB444.
module pong_frame_renderer
   import pong_pkg::*;
#(
   parameter int H_VIS    = H_ACTIVE,
   parameter int H_FPORCH = H_FP,
   parameter int H_SYNCW  = H_SYNC,
   parameter int H_BPORCH = H_BP,
   parameter int V_VIS    = V_ACTIVE,
   parameter int V_FPORCH = V_FP,
   parameter int V_SYNCW  = V_SYNC,
   parameter int V_BPORCH = V_BP,
   parameter int RIGHT_X  = PADDLE_R_X
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   pong_frame_renderer_if.slave  bus
);

   localparam coord_t PADDLE_MAX = coord_t'(V_VIS - PADDLE_H);

   coord_t  h_cnt_s;
   coord_t  v_cnt_s;
   logic    hs_raw_s;
   logic    vs_raw_s;
   logic    active_s;
   logic    frame_end_s;

   vga_timing_gen #(
      .H_VIS    (H_VIS),
      .H_FPORCH (H_FPORCH),
      .H_SYNCW  (H_SYNCW),
      .H_BPORCH (H_BPORCH),
      .V_VIS    (V_VIS),
      .V_FPORCH (V_FPORCH),
      .V_SYNCW  (V_SYNCW),
      .V_BPORCH (V_BPORCH)
   ) u_timing (
      .clk       (ACLK),
      .rst       (ARESET),
      .pix_ce    (bus.pix_ce),
      .h_cnt     (h_cnt_s),
      .v_cnt     (v_cnt_s),
      .hs_raw    (hs_raw_s),
      .vs_raw    (vs_raw_s),
      .active    (active_s),
      .frame_end (frame_end_s)
   );

   coord_t  sh_paddle_l_r;
   coord_t  sh_paddle_r_r;
   coord_t  sh_ball_x_r;
   coord_t  sh_ball_y_r;
   logic    sh_en_r;
   rgb444_t sh_fg_r;
   rgb444_t sh_bg_r;

   // Shadow copy taken only as the last active pixel leaves, so a frame never tears.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         sh_paddle_l_r <= 10'd0;
         sh_paddle_r_r <= 10'd0;
         sh_ball_x_r   <= 10'd0;
         sh_ball_y_r   <= 10'd0;
         sh_en_r       <= 1'b0;
         sh_fg_r       <= 12'h000;
         sh_bg_r       <= 12'h000;
      end else if (frame_end_s) begin
         sh_paddle_l_r <= clamp_paddle(bus.reg_paddle_l, PADDLE_MAX);
         sh_paddle_r_r <= clamp_paddle(bus.reg_paddle_r, PADDLE_MAX);
         sh_ball_x_r   <= bus.reg_ball_x;
         sh_ball_y_r   <= bus.reg_ball_y;
         sh_en_r       <= bus.reg_ctrl[CTRL_EN_BIT];
         sh_fg_r       <= bus.reg_ctrl[CTRL_FG_LSB +: 12];
         sh_bg_r       <= bus.reg_ctrl[CTRL_BG_LSB +: 12];
      end
   end

   logic        frame_start_r;
   logic [15:0] frame_cnt_r;

   // Frame pulse and counter share the shadow-latch event.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         frame_start_r <= 1'b0;
         frame_cnt_r   <= 16'd0;
      end else begin
         frame_start_r <= frame_end_s;
         if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
      end
   end

   logic hit_lp_s;
   logic hit_rp_s;
   logic hit_ball_s;

   assign hit_lp_s   = in_span(h_cnt_s, coord_t'(PADDLE_L_X), 11'(PADDLE_W))
                    && in_span(v_cnt_s, sh_paddle_l_r, 11'(PADDLE_H));
   assign hit_rp_s   = in_span(h_cnt_s, coord_t'(RIGHT_X), 11'(PADDLE_W))
                    && in_span(v_cnt_s, sh_paddle_r_r, 11'(PADDLE_H));
   assign hit_ball_s = in_span(h_cnt_s, sh_ball_x_r, 11'(BALL_SIZE))
                    && in_span(v_cnt_s, sh_ball_y_r, 11'(BALL_SIZE));

   logic hit_lp_r;
   logic hit_rp_r;
   logic hit_ball_r;
   logic active_r;
   logic hs_raw_r;
   logic vs_raw_r;

   // Stage 1: geometry flags and raw syncs for the current raster position.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         hit_lp_r   <= 1'b0;
         hit_rp_r   <= 1'b0;
         hit_ball_r <= 1'b0;
         active_r   <= 1'b0;
         hs_raw_r   <= 1'b1;
         vs_raw_r   <= 1'b1;
      end else if (bus.pix_ce) begin
         hit_lp_r   <= hit_lp_s;
         hit_rp_r   <= hit_rp_s;
         hit_ball_r <= hit_ball_s;
         active_r   <= active_s;
         hs_raw_r   <= hs_raw_s;
         vs_raw_r   <= vs_raw_s;
      end
   end

   rgb444_t pix_s;

   // Colour select: blank outside the picture, background when disabled.
   always_comb begin
      pix_s = 12'h000;
      if (!active_r) begin
         pix_s = 12'h000;
      end else if (!sh_en_r) begin
         pix_s = sh_bg_r;
      end else if (hit_lp_r || hit_rp_r || hit_ball_r) begin
         pix_s = sh_fg_r;
      end else begin
         pix_s = sh_bg_r;
      end
   end

   rgb444_t rgb_r;
   logic    vga_hs_r;
   logic    vga_vs_r;

   // Stage 2: colour and syncs leave together so they stay aligned.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         rgb_r    <= 12'h000;
         vga_hs_r <= 1'b1;
         vga_vs_r <= 1'b1;
      end else if (bus.pix_ce) begin
         rgb_r    <= pix_s;
         vga_hs_r <= hs_raw_r;
         vga_vs_r <= vs_raw_r;
      end
   end

   assign bus.vga_r       = rgb_r[11:8];
   assign bus.vga_g       = rgb_r[7:4];
   assign bus.vga_b       = rgb_r[3:0];
   assign bus.vga_hs      = vga_hs_r;
   assign bus.vga_vs      = vga_vs_r;
   assign bus.frame_start = frame_start_r;
   assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Bench for pong_frame_renderer: a reduced-geometry instance checked every cycle
// against a pixel-rule model plus probe table, and a default-geometry instance for line timing.
module tb_pong_frame_renderer;
   import pong_pkg::*;

   localparam int HV = 64, HFP = 4, HSW = 8, HBP = 4;
   localparam int VV = 80, VFP = 2, VSW = 2, VBP = 4;
   localparam int RX = 48;
   localparam int HT = HV + HFP + HSW + HBP;
   localparam int VT = VV + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;
   localparam int LATCH_IDX = (VV - 1) * HT + (HT - 1);
   localparam int NPROBE = 19;

   typedef struct { logic hs; logic vs; int rgb; int idx; int tag; } pix_t;
   typedef struct { int tag; int x; int y; int rgb; } probe_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pong_frame_renderer_if dut_if();
   pong_frame_renderer_if def_if();

   pong_frame_renderer #(
      .H_VIS(HV), .H_FPORCH(HFP), .H_SYNCW(HSW), .H_BPORCH(HBP),
      .V_VIS(VV), .V_FPORCH(VFP), .V_SYNCW(VSW), .V_BPORCH(VBP), .RIGHT_X(RX)
   ) dut (.ACLK(clk), .ARESET(rst), .bus(dut_if));

   pong_frame_renderer def_dut (.ACLK(clk), .ARESET(rst), .bus(def_if));

   assign def_if.pix_ce       = dut_if.pix_ce;
   assign def_if.reg_paddle_l = dut_if.reg_paddle_l;
   assign def_if.reg_paddle_r = dut_if.reg_paddle_r;
   assign def_if.reg_ball_x   = dut_if.reg_ball_x;
   assign def_if.reg_ball_y   = dut_if.reg_ball_y;
   assign def_if.reg_ctrl     = dut_if.reg_ctrl;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int c, fcnt_m, ticks, last_fs_tick, sm_fall, def_fall;
   int sh_pl, sh_pr, sh_bx, sh_by;
   logic [31:0] sh_ctrl;
   logic fs_m, def_on, sm_prev, def_prev;
   pix_t e1, e2;
   probe_t probes [NPROBE];
   bit probe_done [NPROBE];
   int probes_seen = 0;

   int t_pl, t_pr, t_bx, t_by;
   logic [31:0] t_ctrl;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int in_box(int x, int y, int x0, int y0, int w, int h);
      return (x >= x0 && x < x0 + w && y >= y0 && y < y0 + h) ? 1 : 0;
   endfunction

   function automatic pix_t render(int idx);
      pix_t p;
      int x, y, hit;
      x = idx % HT;
      y = idx / HT;
      p.idx = idx;
      p.tag = fcnt_m;
      p.hs = !(x >= HV + HFP && x < HV + HFP + HSW);
      p.vs = !(y >= VV + VFP && y < VV + VFP + VSW);
      hit = in_box(x, y, 16, sh_pl, 8, 64) + in_box(x, y, RX, sh_pr, 8, 64)
          + in_box(x, y, sh_bx, sh_by, 8, 8);
      if (x >= HV || y >= VV) p.rgb = 0;
      else if (!sh_ctrl[0]) p.rgb = int'(sh_ctrl[27:16]);
      else p.rgb = (hit != 0) ? int'(sh_ctrl[15:4]) : int'(sh_ctrl[27:16]);
      return p;
   endfunction

   task automatic model_reset();
      pix_t idle;
      idle.hs = 1'b1; idle.vs = 1'b1; idle.rgb = 0; idle.idx = -1; idle.tag = -1;
      e1 = idle; e2 = idle;
      c = 0; fcnt_m = 0; fs_m = 1'b0; ticks = 0; last_fs_tick = -1;
      sh_pl = 0; sh_pr = 0; sh_bx = 0; sh_by = 0; sh_ctrl = 32'h0;
      sm_fall = -1; sm_prev = 1'b1;
   endtask

   task automatic step(input logic ce);
      int rgb_dut;
      dut_if.pix_ce = ce;
      @(posedge clk);
      fs_m = 1'b0;
      if (ce) begin
         e2 = e1;
         e1 = render(c);
         if (c == LATCH_IDX) begin
            sh_pl = (int'(dut_if.reg_paddle_l) > VV - 64) ? VV - 64 : int'(dut_if.reg_paddle_l);
            sh_pr = (int'(dut_if.reg_paddle_r) > VV - 64) ? VV - 64 : int'(dut_if.reg_paddle_r);
            sh_bx = int'(dut_if.reg_ball_x);
            sh_by = int'(dut_if.reg_ball_y);
            sh_ctrl = dut_if.reg_ctrl;
            fs_m = 1'b1;
            fcnt_m = (fcnt_m + 1) % 65536;
         end
         c = (c + 1) % FRAME;
         ticks++;
      end
      @(negedge clk);
      rgb_dut = int'({dut_if.vga_r, dut_if.vga_g, dut_if.vga_b});
      check("hs", dut_if.vga_hs, e2.hs);
      check("vs", dut_if.vga_vs, e2.vs);
      check("rgb", rgb_dut, e2.rgb);
      check("frame_start", dut_if.frame_start, fs_m);
      check("frame_cnt", dut_if.frame_cnt, fcnt_m);
      if (dut_if.frame_start) begin
         if (last_fs_tick >= 0) check("fs_interval", ticks - last_fs_tick, FRAME);
         last_fs_tick = ticks;
      end
      if (sm_prev && !dut_if.vga_hs && sm_fall < 0) sm_fall = ticks;
      sm_prev = dut_if.vga_hs;
      for (int i = 0; i < NPROBE; i++) begin
         if (!probe_done[i] && e2.tag == probes[i].tag
             && e2.idx == probes[i].y * HT + probes[i].x) begin
            check($sformatf("probe%0d", i), rgb_dut, probes[i].rgb);
            probe_done[i] = 1'b1;
            probes_seen++;
         end
      end
      if (def_on) begin
         int h;
         h = (ticks - 2) % 800;
         check("def_hs", def_if.vga_hs, (ticks < 2) ? 1 : ((h >= 656 && h < 752) ? 0 : 1));
         check("def_vs", def_if.vga_vs, 1);
         check("def_rgb", int'({def_if.vga_r, def_if.vga_g, def_if.vga_b}), 0);
         if (def_prev && !def_if.vga_hs && def_fall < 0) def_fall = ticks;
         def_prev = def_if.vga_hs;
         if (ticks >= 1600) def_on = 1'b0;
      end
   endtask

   task automatic set_targets();
      case (fcnt_m)
         0, 1: begin
            t_pl = 10; t_pr = 30; t_by = 50; t_ctrl = 32'h000F_F001;
            t_bx = (fcnt_m == 1 && c >= 40 * HT) ? 10 : 30;
         end
         2: begin t_pl = 70; t_pr = 0; t_bx = 60; t_by = 20; t_ctrl = 32'h0000_FFF1; end
         default: begin t_pl = 70; t_pr = 0; t_bx = 60; t_by = 20; t_ctrl = 32'h0AB0_FFF0; end
      endcase
   endtask

   task automatic drive_targets();
      dut_if.reg_paddle_l = coord_t'(t_pl);
      dut_if.reg_paddle_r = coord_t'(t_pr);
      dut_if.reg_ball_x   = coord_t'(t_bx);
      dut_if.reg_ball_y   = coord_t'(t_by);
      dut_if.reg_ctrl     = t_ctrl;
   endtask

   initial begin
      bit reached;
      probes[0]  = '{1, 30, 50, 32'hF00};  probes[1]  = '{1, 37, 57, 32'hF00};
      probes[2]  = '{1, 38, 50, 32'h00F};  probes[3]  = '{1, 29, 50, 32'h00F};
      probes[4]  = '{1, 10, 50, 32'h00F};  probes[5]  = '{1, 16, 10, 32'hF00};
      probes[6]  = '{1, 23, 73, 32'hF00};  probes[7]  = '{1, 23, 74, 32'h00F};
      probes[8]  = '{1, 48, 30, 32'hF00};  probes[9]  = '{2, 10, 50, 32'hF00};
      probes[10] = '{2, 30, 50, 32'h00F};  probes[11] = '{3, 16, 16, 32'hFFF};
      probes[12] = '{3, 23, 79, 32'hFFF};  probes[13] = '{3, 16, 15, 32'h000};
      probes[14] = '{3, 63, 20, 32'hFFF};  probes[15] = '{3, 59, 20, 32'h000};
      probes[16] = '{3, 64, 20, 32'h000};  probes[17] = '{4, 48, 0, 32'hAB0};
      probes[18] = '{4, 64, 0, 32'h000};
      for (int i = 0; i < NPROBE; i++) probe_done[i] = 1'b0;

      dut_if.pix_ce = 1'b0;
      dut_if.reg_paddle_l = 10'd0; dut_if.reg_paddle_r = 10'd0;
      dut_if.reg_ball_x = 10'd0; dut_if.reg_ball_y = 10'd0; dut_if.reg_ctrl = 32'h0;
      model_reset();
      def_on = 1'b0; def_prev = 1'b1; def_fall = -1;
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("rst_hs", dut_if.vga_hs, 1);
      check("rst_vs", dut_if.vga_vs, 1);
      check("rst_rgb", int'({dut_if.vga_r, dut_if.vga_g, dut_if.vga_b}), 0);
      check("rst_frame_cnt", dut_if.frame_cnt, 0);
      check("rst_frame_start", dut_if.frame_start, 0);
      rst = 1'b0;
      def_on = 1'b1;

      reached = 1'b0;
      for (int k = 0; k < 60000; k++) begin
         if (fcnt_m == 4 && c == 10 * HT + 30) begin
            reached = 1'b1;
            break;
         end
         set_targets();
         if (c < 200 || c >= 6000 || c == 40 * HT) drive_targets();
         else if ($urandom_range(0, 15) == 0) begin
            dut_if.reg_paddle_l = coord_t'($urandom_range(0, 1023));
            dut_if.reg_paddle_r = coord_t'($urandom_range(0, 1023));
            dut_if.reg_ball_x   = coord_t'($urandom_range(0, 1023));
            dut_if.reg_ball_y   = coord_t'($urandom_range(0, 1023));
            dut_if.reg_ctrl     = $urandom;
         end
         if (def_on) step(k % 4 == 3);
         else step($urandom_range(0, 3) != 0);
      end
      check("reach_reset_point", reached, 1);
      check("def_first_hs_fall", def_fall, 658);
      check("sm_first_hs_fall", sm_fall, HV + HFP + 2);
      check("probes_seen", probes_seen, NPROBE);
      check("pre_reset_rgb", int'({dut_if.vga_r, dut_if.vga_g, dut_if.vga_b}), 32'hAB0);

      // asynchronous reset mid-line, sampled before any further clock edge
      #2 rst = 1'b1;
      #1;
      check("async_hs", dut_if.vga_hs, 1);
      check("async_vs", dut_if.vga_vs, 1);
      check("async_rgb", int'({dut_if.vga_r, dut_if.vga_g, dut_if.vga_b}), 0);
      check("async_frame_cnt", dut_if.frame_cnt, 0);
      check("async_frame_start", dut_if.frame_start, 0);
      repeat (3) @(negedge clk);
      model_reset();
      rst = 1'b0;
      for (int k = 0; k < 400; k++) step(1'b1);
      check("restart_hs_fall", sm_fall, HV + HFP + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
